// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: accepts opcodes over valid/ready, stretches memory
// phases by MEM_WAIT cycles, splits SWP into read/write phases and supports HALT.
module ctrl_sequencer #(
  parameter int MEM_WAIT = 1,
  parameter bit HALT_EN  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [3:0] i_opcode,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_flush,
  input  logic       i_resume,
  output logic [2:0] o_aluOp,
  output logic       o_useImm,
  output logic       o_useJmp,
  output logic       o_allowJmp,
  output logic       o_memEn,
  output logic       o_memWr,
  output logic       o_wrReg,
  output logic       o_wrCC,
  output logic       o_done,
  output logic       o_halted
);

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0] cntLoad = CW'(MEM_WAIT);

  typedef enum logic [2:0] {IDLE, EXEC, MEM, SWP_RD, SWP_WR, HALT} stateT;

  stateT         state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [3:0]    opReg, opNext;
  logic          haltFirst, haltFirstNext;
  logic          isFinal, ready, accept, active, isNop, strobe;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      opReg     <= 4'b0000;
      haltFirst <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      opReg     <= opNext;
      haltFirst <= haltFirstNext;
    end
  end

  // Controls are decoded from the latched opcode so they stay stable for the whole instruction
  always_comb begin
    isFinal = (state == EXEC) || (((state == MEM) || (state == SWP_WR)) && (cnt == '0));
    ready   = !i_flush && ((state == IDLE) || isFinal);
    accept  = i_valid && ready;
    active  = state inside {EXEC, MEM, SWP_RD, SWP_WR};
    isNop   = (opReg == 4'b0000) || (opReg == 4'b0011);
    strobe  = isFinal && !i_flush;

    o_ready    = ready;
    o_aluOp    = (active && opReg[3]) ? opReg[2:0] : 3'b000;
    o_useImm   = active && !isNop && (!opReg[3] || (opReg == 4'b1010));
    o_useJmp   = active && (opReg == 4'b0111);
    o_allowJmp = active && (opReg == 4'b0010);
    o_memEn    = state inside {MEM, SWP_RD, SWP_WR};
    o_memWr    = ((state == MEM) && (opReg == 4'b0100)) || (state == SWP_WR);
    o_wrReg    = strobe && (opReg[3] || (opReg == 4'b0111) || (opReg == 4'b0101) ||
                            (opReg == 4'b0001));
    o_wrCC     = strobe && opReg[3];
    o_done     = !i_flush && (isFinal || ((state == HALT) && haltFirst));
    o_halted   = (state == HALT);

    stateNext     = state;
    cntNext       = cnt;
    opNext        = opReg;
    haltFirstNext = 1'b0;

    if (i_flush) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else if (accept) begin
      opNext  = i_opcode;
      cntNext = cntLoad;
      casez (i_opcode)
        4'b1???:          stateNext = EXEC;
        4'b0100, 4'b0101: stateNext = MEM;
        4'b0001:          stateNext = SWP_RD;
        4'b0011: begin
          if (HALT_EN) begin
            stateNext     = HALT;
            haltFirstNext = 1'b1;
          end else begin
            stateNext = EXEC;
          end
        end
        default:          stateNext = EXEC;
      endcase
    end else begin
      // Final cycles without a new opcode fall back to IDLE; otherwise count down
      case (state)
        EXEC: stateNext = IDLE;
        MEM, SWP_WR: begin
          if (cnt == '0) stateNext = IDLE;
          else           cntNext   = cnt - CW'(1);
        end
        SWP_RD: begin
          if (cnt == '0) begin
            stateNext = SWP_WR;
            cntNext   = cntLoad;
          end else begin
            cntNext = cnt - CW'(1);
          end
        end
        HALT: if (i_resume) stateNext = IDLE;
        default: stateNext = state;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Table-driven bench for ctrl_sequencer; three instances cover different MEM_WAIT/HALT_EN
// settings and share one stimulus stream, each vector naming the instance it checks.
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] opcode;
  logic       valid, flush, resume;

  logic       rdy[3];
  logic [2:0] alu[3];
  logic       imm[3], jmp[3], allow[3], mEn[3], mWr[3], wReg[3], wCC[3], dn[3], hlt[3];

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.MEM_WAIT(2), .HALT_EN(1'b1)) dutA (
    .i_clk(clk), .i_rstn(rstn), .i_opcode(opcode), .i_valid(valid), .o_ready(rdy[0]),
    .i_flush(flush), .i_resume(resume), .o_aluOp(alu[0]), .o_useImm(imm[0]),
    .o_useJmp(jmp[0]), .o_allowJmp(allow[0]), .o_memEn(mEn[0]), .o_memWr(mWr[0]),
    .o_wrReg(wReg[0]), .o_wrCC(wCC[0]), .o_done(dn[0]), .o_halted(hlt[0]));

  ctrl_sequencer #(.MEM_WAIT(1), .HALT_EN(1'b0)) dutB (
    .i_clk(clk), .i_rstn(rstn), .i_opcode(opcode), .i_valid(valid), .o_ready(rdy[1]),
    .i_flush(flush), .i_resume(resume), .o_aluOp(alu[1]), .o_useImm(imm[1]),
    .o_useJmp(jmp[1]), .o_allowJmp(allow[1]), .o_memEn(mEn[1]), .o_memWr(mWr[1]),
    .o_wrReg(wReg[1]), .o_wrCC(wCC[1]), .o_done(dn[1]), .o_halted(hlt[1]));

  ctrl_sequencer #(.MEM_WAIT(3), .HALT_EN(1'b1)) dutC (
    .i_clk(clk), .i_rstn(rstn), .i_opcode(opcode), .i_valid(valid), .o_ready(rdy[2]),
    .i_flush(flush), .i_resume(resume), .o_aluOp(alu[2]), .o_useImm(imm[2]),
    .o_useJmp(jmp[2]), .o_allowJmp(allow[2]), .o_memEn(mEn[2]), .o_memWr(mWr[2]),
    .o_wrReg(wReg[2]), .o_wrCC(wCC[2]), .o_done(dn[2]), .o_halted(hlt[2]));

  typedef struct {
    int          sel;
    bit          rstFirst;
    logic [3:0]  op;
    logic        valid;
    logic        flush;
    logic        resume;
    logic [12:0] exp;
    string       name;
  } vecT;

  vecT vecs[$];

  // Output word layout: {ready, aluOp, useImm, useJmp, allowJmp, memEn, memWr, wrReg, wrCC, done, halted}
  function automatic logic [12:0] ex(input logic r, input logic [2:0] a, input logic i, j, al,
                                     me, mw, wr, wc, d, h);
    return {r, a, i, j, al, me, mw, wr, wc, d, h};
  endfunction

  function automatic logic [12:0] actual(input int s);
    return {rdy[s], alu[s], imm[s], jmp[s], allow[s], mEn[s], mWr[s], wReg[s], wCC[s], dn[s],
            hlt[s]};
  endfunction

  task automatic addVec(input int sel, input bit rf, input logic [3:0] op, input logic v, f, r,
                        input logic [12:0] e, input string n);
    vecT t;
    t.sel = sel; t.rstFirst = rf; t.op = op; t.valid = v; t.flush = f; t.resume = r;
    t.exp = e; t.name = n;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input vecT t);
    if (t.rstFirst) begin
      rstn = 1'b0;
      #2;
      rstn = 1'b1;
    end
    opcode = t.op;
    valid  = t.valid;
    flush  = t.flush;
    resume = t.resume;
  endtask

  task automatic checkOutput(input string n, input logic [12:0] act, input logic [12:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  // Reset asserted mid-SWP must clear everything at once, then a JLR must issue normally
  task automatic asyncResetSeq();
    logic [12:0] idleExp;
    idleExp = ex(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    opcode = 4'b0001; valid = 1'b1; flush = 1'b0; resume = 1'b0;
    @(negedge clk); checkOutput("t7Idle", actual(1), idleExp);
    @(posedge clk); #1; valid = 1'b0;
    @(negedge clk); checkOutput("t7SwpRd", actual(1), ex(0, 3'b000, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rstn = 1'b0;
    #1; checkOutput("t7AsyncRst", actual(1), idleExp);
    #1; rstn = 1'b1;
    @(posedge clk); #1; opcode = 4'b0111; valid = 1'b1;
    @(negedge clk); checkOutput("t7Idle2", actual(1), idleExp);
    @(posedge clk); #1; valid = 1'b0;
    @(negedge clk); checkOutput("t7Jlr", actual(1), ex(1, 3'b000, 1, 1, 0, 0, 0, 1, 0, 1, 0));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [12:0] idle, haltOnly;
    idle     = ex(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    haltOnly = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Back-to-back ALU ops
    addVec(0, 1, 4'b1000, 1, 0, 0, idle, "t1Idle");
    addVec(0, 0, 4'b1011, 1, 0, 0, ex(1, 3'b000, 0, 0, 0, 0, 0, 1, 1, 1, 0), "t1Add");
    addVec(0, 0, 4'b1010, 1, 0, 0, ex(1, 3'b011, 0, 0, 0, 0, 0, 1, 1, 1, 0), "t1And");
    addVec(0, 0, 4'b0000, 0, 0, 0, ex(1, 3'b010, 1, 0, 0, 0, 0, 1, 1, 1, 0), "t1Imm");
    addVec(0, 0, 4'b0000, 0, 0, 0, idle, "t1Back");
    // LDR with MEM_WAIT=2, ADD held on the bus and accepted in the final cycle
    addVec(0, 1, 4'b0101, 1, 0, 0, idle, "t2Idle");
    addVec(0, 0, 4'b1000, 1, 0, 0, ex(0, 3'b000, 1, 0, 0, 1, 0, 0, 0, 0, 0), "t2Wait1");
    addVec(0, 0, 4'b1000, 1, 0, 0, ex(0, 3'b000, 1, 0, 0, 1, 0, 0, 0, 0, 0), "t2Wait2");
    addVec(0, 0, 4'b1000, 1, 0, 0, ex(1, 3'b000, 1, 0, 0, 1, 0, 1, 0, 1, 0), "t2Final");
    addVec(0, 0, 4'b0000, 0, 0, 0, ex(1, 3'b000, 0, 0, 0, 0, 0, 1, 1, 1, 0), "t2Add");
    addVec(0, 0, 4'b0000, 0, 0, 0, idle, "t2Back");
    // SWP with MEM_WAIT=1, then HLT as NOP and BRC on the HALT_EN=0 instance
    addVec(1, 1, 4'b0001, 1, 0, 0, idle, "t3Idle");
    addVec(1, 0, 4'b0000, 0, 0, 0, ex(0, 3'b000, 1, 0, 0, 1, 0, 0, 0, 0, 0), "t3Rd1");
    addVec(1, 0, 4'b0000, 0, 0, 0, ex(0, 3'b000, 1, 0, 0, 1, 0, 0, 0, 0, 0), "t3Rd2");
    addVec(1, 0, 4'b0000, 0, 0, 0, ex(0, 3'b000, 1, 0, 0, 1, 1, 0, 0, 0, 0), "t3Wr1");
    addVec(1, 0, 4'b0000, 0, 0, 0, ex(1, 3'b000, 1, 0, 0, 1, 1, 1, 0, 1, 0), "t3Wr2");
    addVec(1, 0, 4'b0011, 1, 0, 0, idle, "t3Idle2");
    addVec(1, 0, 4'b0010, 1, 0, 0, ex(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0), "t3HltNop");
    addVec(1, 0, 4'b0000, 0, 0, 0, ex(1, 3'b000, 1, 0, 1, 0, 0, 0, 0, 1, 0), "t3Brc");
    addVec(1, 0, 4'b0000, 0, 0, 0, idle, "t3Back");
    // HALT ignores valid for 10 cycles until resumed
    addVec(0, 1, 4'b0011, 1, 0, 0, idle, "t4Idle");
    addVec(0, 0, 4'b1000, 1, 0, 0, ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 1), "t4Entry");
    for (int i = 0; i < 9; i++) addVec(0, 0, 4'b1000, 1, 0, 0, haltOnly, "t4Held");
    addVec(0, 0, 4'b1000, 1, 0, 1, haltOnly, "t4Resume");
    addVec(0, 0, 4'b0000, 0, 0, 0, idle, "t4Ready");
    // Flush mid-STR and in the final EXEC cycle
    addVec(2, 1, 4'b0100, 1, 0, 0, idle, "t5Idle");
    addVec(2, 0, 4'b0000, 0, 0, 0, ex(0, 3'b000, 1, 0, 0, 1, 1, 0, 0, 0, 0), "t5Mem");
    addVec(2, 0, 4'b0000, 0, 1, 0, ex(0, 3'b000, 1, 0, 0, 1, 1, 0, 0, 0, 0), "t5Flush");
    addVec(2, 0, 4'b1000, 1, 0, 0, idle, "t5Idle2");
    addVec(2, 0, 4'b1011, 1, 1, 0, ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "t5FlushExec");
    addVec(2, 0, 4'b0000, 0, 0, 0, idle, "t5NoAccept");
    // Flush and resume together on HALT entry
    addVec(0, 1, 4'b0011, 1, 0, 0, idle, "t6Idle");
    addVec(0, 0, 4'b0000, 0, 1, 1, haltOnly, "t6FlushHalt");
    addVec(0, 0, 4'b0000, 0, 0, 0, idle, "t6Back");

    rstn = 1'b0; opcode = 4'b0000; valid = 1'b0; flush = 1'b0; resume = 1'b0;
    #2;
    for (int s = 0; s < 3; s++) checkOutput("resetState", actual(s), idle);
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i].name, actual(vecs[i].sel), vecs[i].exp);
      @(posedge clk); #1;
    end

    asyncResetSeq();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
